// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-requester SRAM arbiter: default sizes and
// the encoding that tags each in-flight access with its owner.
package sram_arbiter_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int STARVE_CNT_W     = 4;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_e;

endpackage

// File: rtl/sram_arb_starve_ctr.sv
// Counts consecutive cycles in which fetch is requesting but refused, and
// raises force_if once that run reaches STARVE_LIMIT.
module sram_arb_starve_ctr
  import sram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ifReq,
  input  logic i_grantIf,
  output logic o_forceIf
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT   = STARVE_CNT_W'(STARVE_LIMIT);
  localparam logic [STARVE_CNT_W-1:0] SAT_MAX = '1;

  logic [STARVE_CNT_W-1:0] r_starveCnt;

  // Any fetch grant or a withdrawn fetch request ends the refusal run.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starveCnt <= '0;
    end else if (i_grantIf || !i_ifReq) begin
      r_starveCnt <= '0;
    end else if (r_starveCnt != SAT_MAX) begin
      r_starveCnt <= r_starveCnt + STARVE_CNT_W'(1);
    end
  end

  assign o_forceIf = (r_starveCnt >= LIMIT);

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and the
// data path; data wins unless fetch has been starved for too long.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_addr_ok,
  output logic                if_data_ok,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                mem_req,
  input  logic                mem_wr,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_addr_ok,
  output logic                mem_data_ok,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  logic   w_forceIf;
  logic   w_grantIf;
  logic   w_grantMem;
  logic   r_respValid;
  owner_e r_respOwner;

  assign w_grantMem = mem_req & ~w_forceIf & ~reset;
  assign w_grantIf  = if_req & (~mem_req | w_forceIf) & ~reset;

  sram_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starveCtr (
    .clk      (clk),
    .reset    (reset),
    .i_ifReq  (if_req),
    .i_grantIf(w_grantIf),
    .o_forceIf(w_forceIf)
  );

  assign if_addr_ok  = w_grantIf;
  assign mem_addr_ok = w_grantMem;

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (w_grantMem) begin
      sram_en    = 1'b1;
      sram_we    = mem_wr ? mem_wstrb : '0;
      sram_addr  = mem_addr;
      sram_wdata = mem_wdata;
    end else if (w_grantIf) begin
      sram_en    = 1'b1;
      sram_addr  = if_addr;
    end
  end

  // Remember who owns the access issued this cycle so its data can be
  // steered back when the SRAM answers next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_respValid <= 1'b0;
      r_respOwner <= OWNER_IF;
    end else begin
      r_respValid <= w_grantIf | w_grantMem;
      r_respOwner <= w_grantMem ? OWNER_MEM : OWNER_IF;
    end
  end

  // Reset in the response cycle drops the pending answer.
  assign if_data_ok  = r_respValid & (r_respOwner == OWNER_IF)  & ~reset;
  assign mem_data_ok = r_respValid & (r_respOwner == OWNER_MEM) & ~reset;
  assign if_rdata    = sram_rdata;
  assign mem_rdata   = sram_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a reference model.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int LIMIT = 4;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam logic [31:0] IFA  = 32'h0000_0200;
  localparam logic [31:0] MEMA = 32'h0000_0300;
  localparam logic [31:0] IFD  = 32'h0200_FDFF;
  localparam logic [31:0] MEMD = 32'h0300_FCFF;

  logic        clk, reset;
  logic        if_req, if_addr_ok, if_data_ok;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  int nChecks = 0;
  int nFails  = 0;
  int vecNum  = 0;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_addr_ok(if_addr_ok),
    .if_data_ok(if_data_ok), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural SRAM macro: read-first, byte-maskable, one-cycle latency.
  logic [31:0] sramMem [logic [31:0]];
  logic [31:0] sramOld;

  function automatic logic [31:0] defaultWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge clk) begin
    if (sram_en) begin
      sramOld = sramMem.exists(sram_addr) ? sramMem[sram_addr] : defaultWord(sram_addr);
      sram_rdata <= sramOld;
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) sramOld[8*b +: 8] = sram_wdata[8*b +: 8];
      sramMem[sram_addr] = sramOld;
    end
  end

  typedef struct {
    logic        rst, ifReq;
    logic [31:0] ifAddr;
    logic        memReq, memWr;
    logic [3:0]  memStrb;
    logic [31:0] memAddr, memWdata;
    logic        eIfOk, eMemOk, eIfData, eMemData, chkRdata;
    logic [31:0] eRdata;
  } vec_t;

  function automatic vec_t mkVec(input logic rst, ifReq, input logic [31:0] ifAddr,
                                 input logic memReq, memWr, input logic [3:0] strb,
                                 input logic [31:0] memAddr, wdata,
                                 input logic eIfOk, eMemOk, eIfData, eMemData, chk,
                                 input logic [31:0] eRdata);
    vec_t v;
    v.rst = rst; v.ifReq = ifReq; v.ifAddr = ifAddr;
    v.memReq = memReq; v.memWr = memWr; v.memStrb = strb;
    v.memAddr = memAddr; v.memWdata = wdata;
    v.eIfOk = eIfOk; v.eMemOk = eMemOk; v.eIfData = eIfData; v.eMemData = eMemData;
    v.chkRdata = chk; v.eRdata = eRdata;
    return v;
  endfunction

  task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", what, act, exp);
    end
  endtask

  task automatic driveInputs(input logic rst, ifReq, input logic [31:0] ifAddr,
                             input logic memReq, memWr, input logic [3:0] strb,
                             input logic [31:0] memAddr, wdata);
    reset = rst; if_req = ifReq; if_addr = ifAddr;
    mem_req = memReq; mem_wr = memWr; mem_wstrb = strb;
    mem_addr = memAddr; mem_wdata = wdata;
  endtask

  // Compare every output against the expected grant/response picture.
  task automatic checkAll(input string tag, input logic eIfOk, eMemOk, eIfData, eMemData,
                          input logic [3:0] eWe, input logic [31:0] eAddr, eWdata,
                          input logic chk, input logic [31:0] eRdata);
    checkOutput({tag, ".if_addr_ok"},  {31'b0, if_addr_ok},  {31'b0, eIfOk});
    checkOutput({tag, ".mem_addr_ok"}, {31'b0, mem_addr_ok}, {31'b0, eMemOk});
    checkOutput({tag, ".if_data_ok"},  {31'b0, if_data_ok},  {31'b0, eIfData});
    checkOutput({tag, ".mem_data_ok"}, {31'b0, mem_data_ok}, {31'b0, eMemData});
    checkOutput({tag, ".sram_en"},     {31'b0, sram_en},     {31'b0, eIfOk | eMemOk});
    checkOutput({tag, ".sram_we"},     {28'b0, sram_we},     {28'b0, eWe});
    checkOutput({tag, ".sram_addr"},   sram_addr,  eAddr);
    checkOutput({tag, ".sram_wdata"},  sram_wdata, eWdata);
    if (chk) begin
      if (eIfData) checkOutput({tag, ".if_rdata"}, if_rdata, eRdata);
      if (eMemData) checkOutput({tag, ".mem_rdata"}, mem_rdata, eRdata);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [3:0]  eWe;
    logic [31:0] eAddr, eWdata;
    @(negedge clk);
    driveInputs(v.rst, v.ifReq, v.ifAddr, v.memReq, v.memWr, v.memStrb, v.memAddr, v.memWdata);
    #1;
    eWe    = (v.eMemOk && v.memWr) ? v.memStrb : 4'h0;
    eAddr  = v.eMemOk ? v.memAddr : (v.eIfOk ? v.ifAddr : 32'h0);
    eWdata = v.eMemOk ? v.memWdata : 32'h0;
    checkAll($sformatf("vec%0d", vecNum), v.eIfOk, v.eMemOk, v.eIfData, v.eMemData,
             eWe, eAddr, eWdata, v.chkRdata, v.eRdata);
    vecNum++;
  endtask

  // Both requesters hold reads; IF is expected to win only at cycle ifAt.
  task automatic runContention(input int n, input int ifAt, input logic prevValid, input logic prevIsIf);
    logic pv, pIf, gIf;
    pv = prevValid; pIf = prevIsIf;
    for (int k = 0; k < n; k++) begin
      gIf = (k == ifAt);
      applyStimulus(mkVec(N, Y, IFA, Y, N, 4'h0, MEMA, 32'h0,
                          gIf, !gIf, pv && pIf, pv && !pIf, pv, pIf ? IFD : MEMD));
      pv = Y; pIf = gIf;
    end
    applyStimulus(mkVec(N, N, 32'h0, N, N, 4'h0, 32'h0, 32'h0,
                        N, N, pIf, !pIf, Y, pIf ? IFD : MEMD));
  endtask

  logic [31:0] refMem [logic [31:0]];

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : defaultWord(a);
  endfunction

  // Randomized traffic with handshake-obeying requesters; the model tracks
  // the refusal run, the one outstanding response and the memory contents.
  task automatic runRandom(input int nCycles);
    int          refused;
    logic        pv, pIsMem, pRead, rst, force_, gIf, gMem;
    logic [31:0] pData, wordNow;
    logic        ifAct, memAct, memW;
    logic [31:0] ifA, memA, wd;
    logic [3:0]  strb;
    refused = 0; pv = N; pIsMem = N; pRead = N; pData = 32'h0;
    ifAct = N; memAct = N; memW = N; ifA = 32'h0; memA = 32'h0; wd = 32'h0; strb = 4'h0;
    for (int c = 0; c < nCycles; c++) begin
      @(negedge clk);
      rst = (c < 2) || ($urandom_range(0, 63) == 0);
      if (!ifAct && $urandom_range(0, 3) != 0) begin
        ifAct = Y;
        ifA = 32'h2000 + 32'($urandom_range(0, 15)) * 4;
      end
      if (!memAct && $urandom_range(0, 2) != 0) begin
        memAct = Y;
        memW = 1'($urandom_range(0, 1));
        strb = 4'($urandom);
        memA = 32'h2000 + 32'($urandom_range(0, 15)) * 4;
        wd = $urandom;
      end
      driveInputs(rst, ifAct, ifA, memAct, memW, strb, memA, wd);
      #1;
      if (rst) begin
        checkAll($sformatf("rnd%0d", c), N, N, N, N, 4'h0, 32'h0, 32'h0, N, 32'h0);
        refused = 0; pv = N;
      end else begin
        force_ = (refused >= LIMIT);
        gMem = memAct && !force_;
        gIf  = ifAct && (!memAct || force_);
        checkAll($sformatf("rnd%0d", c), gIf, gMem, pv && !pIsMem, pv && pIsMem,
                 (gMem && memW) ? strb : 4'h0,
                 gMem ? memA : (gIf ? ifA : 32'h0), gMem ? wd : 32'h0,
                 pv && pRead, pData);
        pv = gMem || gIf;
        pIsMem = gMem;
        pRead = gIf || (gMem && !memW);
        pData = gMem ? refRead(memA) : refRead(ifA);
        if (gMem && memW) begin
          wordNow = refRead(memA);
          for (int b = 0; b < 4; b++)
            if (strb[b]) wordNow[8*b +: 8] = wd[8*b +: 8];
          refMem[memA] = wordNow;
        end
        refused = (gIf || !ifAct) ? 0 : ((refused < 15) ? refused + 1 : 15);
        if (gIf) ifAct = N;
        if (gMem) memAct = N;
      end
    end
  endtask

  vec_t tbl[$];

  initial begin
    driveInputs(Y, N, 32'h0, N, N, 4'h0, 32'h0, 32'h0);
    sramMem[32'h1C00_0000] = 32'hDEAD_BEEF;
    sramMem[32'h0000_0100] = 32'hAAAA_AAAA;

    tbl.push_back(mkVec(Y, Y, 32'h1C00_0000, Y, N, 4'h0, 32'h100, 32'h0, N, N, N, N, N, 32'h0));
    tbl.push_back(mkVec(Y, N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, N, N, N, N, N, 32'h0));
    tbl.push_back(mkVec(N, Y, 32'h1C00_0000, N, N, 4'h0, 32'h0, 32'h0, Y, N, N, N, N, 32'h0));
    tbl.push_back(mkVec(N, N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, N, N, Y, N, Y, 32'hDEAD_BEEF));
    tbl.push_back(mkVec(N, N, 32'h0, Y, Y, 4'b0011, 32'h100, 32'h1234_5678, N, Y, N, N, N, 32'h0));
    tbl.push_back(mkVec(N, N, 32'h0, Y, N, 4'hF, 32'h100, 32'h0, N, Y, N, Y, N, 32'h0));
    tbl.push_back(mkVec(N, N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, N, N, N, Y, Y, 32'hAAAA_5678));
    for (int k = 0; k < 10; k++) begin
      tbl.push_back(mkVec(N, Y, IFA, Y, N, 4'h0, MEMA, 32'h0,
                          (k == 4 || k == 9), !(k == 4 || k == 9),
                          (k == 5), (k != 0 && k != 5), (k != 0), (k == 5) ? IFD : MEMD));
    end
    tbl.push_back(mkVec(N, N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, N, N, Y, N, Y, IFD));
    tbl.push_back(mkVec(N, Y, 32'h400, N, N, 4'h0, 32'h0, 32'h0, Y, N, N, N, N, 32'h0));
    tbl.push_back(mkVec(N, N, 32'h0, Y, N, 4'h0, 32'h500, 32'h0, N, Y, Y, N, Y, 32'h0400_FBFF));
    tbl.push_back(mkVec(N, Y, 32'h404, N, N, 4'h0, 32'h0, 32'h0, Y, N, N, Y, Y, 32'h0500_FAFF));
    tbl.push_back(mkVec(N, N, 32'h0, Y, Y, 4'hF, 32'h504, 32'hCAFE_F00D, N, Y, Y, N, Y, 32'h0404_FBFB));
    tbl.push_back(mkVec(N, N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, N, N, N, Y, N, 32'h0));

    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);

    $display("[TB] reset during a pending MEM response");
    applyStimulus(mkVec(N, Y, IFA, Y, N, 4'h0, MEMA, 32'h0, N, Y, N, N, N, 32'h0));
    applyStimulus(mkVec(Y, Y, IFA, Y, N, 4'h0, MEMA, 32'h0, N, N, N, N, N, 32'h0));
    runContention(6, 4, N, N);

    $display("[TB] IF withdraws while refused");
    applyStimulus(mkVec(N, Y, IFA, Y, N, 4'h0, MEMA, 32'h0, N, Y, N, N, N, 32'h0));
    applyStimulus(mkVec(N, Y, IFA, Y, N, 4'h0, MEMA, 32'h0, N, Y, N, Y, Y, MEMD));
    applyStimulus(mkVec(N, N, IFA, Y, N, 4'h0, MEMA, 32'h0, N, Y, N, Y, Y, MEMD));
    runContention(5, 4, Y, N);

    $display("[TB] randomized traffic");
    runRandom(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one single-port synchronous SRAM (1-cycle read latency) between two requesters: instruction fetch (IF) and the data access issued by the execute stage and completed in MEM.
- Sits between the pipeline stages and the SRAM macro.
- Arbitrates one request per cycle and records who owns each issued access. The next cycle it routes read data and a data_ok pulse back to that owner.
- Data requests normally win. A starvation counter guarantees fetch progress.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte strobes = DATA_W/8)
STARVE_LIMIT, 4, consecutive cycles IF may be refused while requesting before it gets forced priority (range 1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held with if_addr until if_addr_ok
if_addr  in  ADDR_W  fetch address
if_addr_ok  out  1  fetch request accepted this cycle
if_data_ok  out  1  fetch read data valid this cycle
if_rdata  out  DATA_W  fetch read data
mem_req  in  1  data request; held with fields until mem_addr_ok
mem_wr  in  1  1 = write, 0 = read
mem_wstrb  in  DATA_W/8  byte write enables (ignored on read)
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  store data
mem_addr_ok  out  1  data request accepted this cycle
mem_data_ok  out  1  data response (read data or write ack) this cycle
mem_rdata  out  DATA_W  load data
sram_en  out  1  SRAM enable
sram_we  out  DATA_W/8  SRAM byte write enables
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_rdata  in  DATA_W  SRAM read data, valid 1 cycle after enable

Behaviour:
- Grant logic is combinational from the requests and registered state.
  - grant_mem = mem_req & !force_if.
  - grant_if = if_req & (!mem_req | force_if).
  - force_if = (starve_cnt >= STARVE_LIMIT).
  - Both grants are gated by !reset.
- SRAM mux:
  - On grant_mem: sram_en=1, sram_we = mem_wr ? mem_wstrb : 0, sram_addr=mem_addr, sram_wdata=mem_wdata.
  - On grant_if: sram_en=1, sram_we=0, sram_addr=if_addr, sram_wdata=0.
  - With no grant: sram_en=0, sram_we=0; addr and wdata drive 0.
- if_addr_ok = grant_if; mem_addr_ok = grant_mem. At most one is high per cycle.
- Response registers, updated every cycle:
  - resp_valid <= grant_if | grant_mem.
  - resp_owner <= grant_mem (1 = MEM, 0 = IF).
- Response outputs in the cycle after a grant:
  - if_data_ok = resp_valid & !resp_owner.
  - mem_data_ok = resp_valid & resp_owner.
  - if_rdata = mem_rdata = sram_rdata, passed unregistered.
  - A write also produces a mem_data_ok pulse; mem_rdata is don't-care on writes.
- Throughput is one access per cycle, back-to-back with no bubble. Latency is request-accept to data_ok = 1 cycle.
- Starvation counter starve_cnt, 4 bits:
  - Cleared when grant_if is high or if_req is low.
  - Otherwise incremented, saturating at 15.
  - After STARVE_LIMIT refused cycles, IF is granted exactly once and the counter clears, so MEM regains priority next cycle.
- A forced IF grant refuses MEM (mem_addr_ok=0). MEM must hold its request and gets the next grant.
- Simultaneous requests without force: MEM wins, IF is refused and starve_cnt increments.
- Reset:
  - starve_cnt=0, resp_valid=0, resp_owner=0.
  - During reset all outputs are 0: addr_ok, data_ok, sram_en, sram_we.
- Reset asserted in the cycle after a grant: the pending response is dropped and no data_ok is issued.
- Requester handshake rule: req and its fields are stable from assertion until addr_ok. The arbiter does not check this.

Decomposition:
- Shared package holds:
  - owner encoding constants OWNER_IF=0 and OWNER_MEM=1;
  - the default widths;
  - the STARVE_LIMIT default.
- One natural sub-module: sram_arb_starve_ctr, the saturating starvation counter with its force_if output.
- Mux, grant and response logic stay in the top module.

Test Plan:
- Lone IF read: if_req=1, if_addr=0x1C00_0000, SRAM word 0xDEAD_BEEF -> if_addr_ok in cycle 0, sram_en=1, sram_we=0; cycle 1 if_data_ok=1, if_rdata=0xDEAD_BEEF, mem_data_ok=0.
- MEM store then load to 0x100: write wstrb=4'b0011, wdata=0x1234_5678 over old 0xAAAA_AAAA -> mem_data_ok pulses the next cycle. Following load returns 0xAAAA_5678 one cycle after its addr_ok.
- Contention: if_req and mem_req high continuously, STARVE_LIMIT=4 -> MEM granted cycles 0-3, IF granted cycle 4, MEM cycles 5-8, IF cycle 9. data_ok owners follow one cycle later, with no bubbles.
- Back-to-back mixed: alternating IF/MEM reads on consecutive cycles -> each data_ok goes to the correct owner with its own data. if_data_ok and mem_data_ok are never high together.
- Reset mid-flight: grant MEM read in cycle 0, reset=1 in cycle 1 -> mem_data_ok=0 in cycle 1 and all outputs 0. After reset deasserts, starve_cnt starts from 0.
- IF drops its request while refused: if_req high for 2 refused cycles, then low -> starve_cnt clears. A later contention needs 4 fresh refusals before IF is forced.
